// File: rtl/rv32i_wb_stage.sv
// rv32i_wb_stage: writeback stage of the RV32I pipeline.
// Retires ALU results one cycle after transfer and loads once the data memory
// answers. Load data is byte/half extended, and then the register file write
// port is driven.
// Optional feature: define WB_FORWARD_EN to add the same-cycle forwarding
// outputs fwd_valid/fwd_reg/fwd_data.
module rv32i_wb_stage #(
  parameter int CNT_W        = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_result,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             wb_enable,
  output logic [4:0]       wb_reg,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_count,
  output logic             load_err
`ifdef WB_FORWARD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  // Wide enough to hold LOAD_TIMEOUT-1 for any LOAD_TIMEOUT >= 1.
  localparam int                TMR_W     = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOAD_TIMEOUT - 1);

  logic [0:0]       state;
  logic [4:0]       ld_rd;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic [TMR_W-1:0] timer;
  logic             transfer;

  // Selects the addressed byte/half of the aligned word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {addr_lo, 3'b000});
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Accept only in IDLE, and never while reset is held.
  assign in_ready = (state == IDLE) && !reset;
  assign transfer = in_valid && in_ready;

  // FSM, write-port registers, retire counter and sticky timeout flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_addr_lo   <= '0;
      timer        <= '0;
      wb_enable    <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      retire_count <= '0;
      load_err     <= 1'b0;
    end else begin
      // NOTE: the default de-assertion makes wb_enable a one-cycle pulse;
      // wb_reg/wb_data are only written alongside it, so they hold otherwise.
      wb_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (in_is_load) begin
              ld_rd      <= in_rd;
              ld_funct3  <= in_funct3;
              ld_addr_lo <= in_addr_lo;
              timer      <= '0;
              state      <= WAIT_LOAD;
            end else begin
              retire_count <= retire_count + CNT_W'(1);
              if (in_rd != 5'd0) begin
                wb_enable <= 1'b1;
                wb_reg    <= in_rd;
                wb_data   <= in_result;
              end
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            retire_count <= retire_count + CNT_W'(1);
            if (ld_rd != 5'd0) begin
              wb_enable <= 1'b1;
              wb_reg    <= ld_rd;
              wb_data   <= load_extend(ld_funct3, ld_addr_lo, dmem_rdata);
            end
            state <= IDLE;
          end else if (timer == TMR_LAST) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  // Same-cycle bypass of the value the register file is being written with.
  assign fwd_valid = wb_enable;
  assign fwd_reg   = wb_reg;
  assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Directed bench for rv32i_wb_stage: ALU retire, load extension, load wait,
// rd==0, spurious rvalid, load timeout and reset during a pending load.
module tb_rv32i_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] retire_count;
  logic        load_err;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32i_wb_stage #(.CNT_W(32), .LOAD_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_addr_lo   (in_addr_lo),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_enable    (wb_enable),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .retire_count (retire_count),
    .load_err     (load_err)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load issued at addr_lo with rvalid on the very next cycle (earliest writeback).
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] word, input logic [31:0] exp);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd3; in_funct3 = f3; in_addr_lo = lo;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    check({tag, "_ready_low"}, {31'b0, in_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = word;
    tick();
    dmem_rvalid = 1'b0;
    check({tag, "_en"}, {31'b0, wb_enable}, 32'd1);
    check({tag, "_data"}, wb_data, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_en", {31'b0, wb_enable}, 32'd0);
    check("rst_reg", {27'b0, wb_reg}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_count", retire_count, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_ready", {31'b0, in_ready}, 32'd1);

    // ALU rd=5, then a back-to-back ALU rd=6.
    in_valid = 1'b1; in_rd = 5'd5; in_result = 32'hDEADBEEF;
    tick();
    check("alu_en", {31'b0, wb_enable}, 32'd1);
    check("alu_reg", {27'b0, wb_reg}, 32'd5);
    check("alu_data", wb_data, 32'hDEADBEEF);
    check("alu_count", retire_count, 32'd1);
    in_rd = 5'd6; in_result = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    check("b2b_en", {31'b0, wb_enable}, 32'd1);
    check("b2b_reg", {27'b0, wb_reg}, 32'd6);
    check("b2b_count", retire_count, 32'd2);
    tick();
    check("pulse_en", {31'b0, wb_enable}, 32'd0);
    check("hold_reg", {27'b0, wb_reg}, 32'd6);
    check("hold_data", wb_data, 32'h0000_1234);

    // rd=0: no write, still retired.
    in_valid = 1'b1; in_rd = 5'd0; in_result = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    check("rd0_en", {31'b0, wb_enable}, 32'd0);
    check("rd0_data", wb_data, 32'h0000_1234);
    check("rd0_count", retire_count, 32'd3);

    // Load extension.
    quick_load("lb3",  3'b000, 2'd3, 32'h80123456, 32'hFFFFFF80);
    quick_load("lbu3", 3'b100, 2'd3, 32'h80123456, 32'h00000080);
    quick_load("lh2",  3'b001, 2'd2, 32'h80123456, 32'hFFFF8012);
    quick_load("lhu3", 3'b101, 2'd3, 32'h80123456, 32'h00008012);
    quick_load("lb0",  3'b000, 2'd0, 32'h80123456, 32'h00000056);
    quick_load("lh0",  3'b001, 2'd1, 32'h8012F456, 32'hFFFFF456);
    quick_load("lw",   3'b010, 2'd0, 32'h80123456, 32'h80123456);
    quick_load("f011", 3'b011, 2'd2, 32'hA5A5_0001, 32'hA5A5_0001);
    check("load_count", retire_count, 32'd11);
    check("load_reg", {27'b0, wb_reg}, 32'd3);

    // Load whose rvalid comes 4 cycles after transfer; ALU offered meanwhile.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    tick();
    in_is_load = 1'b0; in_rd = 5'd9; in_result = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      check("wait_ready", {31'b0, in_ready}, 32'd0);
      tick();
      check("wait_en", {31'b0, wb_enable}, 32'd0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    check("wait_ready4", {31'b0, in_ready}, 32'd0);
    tick();
    dmem_rvalid = 1'b0; in_valid = 1'b0;
    check("slow_en", {31'b0, wb_enable}, 32'd1);
    check("slow_reg", {27'b0, wb_reg}, 32'd7);
    check("slow_data", wb_data, 32'hCAFEF00D);
    check("slow_count", retire_count, 32'd12);
    tick();
    check("blocked_alu_en", {31'b0, wb_enable}, 32'd0);
    check("blocked_alu_count", retire_count, 32'd12);

    // Spurious rvalid in IDLE.
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    check("spur_en", {31'b0, wb_enable}, 32'd0);
    check("spur_count", retire_count, 32'd12);

    // Timeout: 16 cycles in WAIT_LOAD without rvalid.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd8;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_err_early", {31'b0, load_err}, 32'd0);
    check("to_ready_early", {31'b0, in_ready}, 32'd0);
    tick();
    check("to_err", {31'b0, load_err}, 32'd1);
    check("to_ready", {31'b0, in_ready}, 32'd1);
    check("to_en", {31'b0, wb_enable}, 32'd0);
    check("to_count", retire_count, 32'd12);
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    check("late_en", {31'b0, wb_enable}, 32'd0);
    check("late_count", retire_count, 32'd12);
    check("err_sticky", {31'b0, load_err}, 32'd1);

    // Reset while waiting for load data; rvalid arrives right after reset.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd10;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    reset = 1'b1;
    tick();
    check("rst2_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("rst2_en", {31'b0, wb_enable}, 32'd0);
    check("rst2_reg", {27'b0, wb_reg}, 32'd0);
    check("rst2_data", wb_data, 32'd0);
    check("rst2_count", retire_count, 32'd0);
    check("rst2_err", {31'b0, load_err}, 32'd0);
    check("rst2_idle", {31'b0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
